// File: rtl/fu_logic_pipe_if.sv
// Issue / completion bus of the pipelined logic functional unit.
// Dispatch and the broadcast queue sit on the master side; the unit is the slave.
//   ce, opcode, executionTag_in, data_0, data_1 : issue from dispatch
//   idle                                         : unit can take an issue this cycle
//   result, done, executionTag_out               : head of the completion buffer
//   queued                                       : broadcast queue takes the head entry
interface fu_logic_pipe_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TAG_WIDTH  = 7
);
   logic                  ce;
   logic                  idle;
   logic [2:0]            opcode;
   logic [TAG_WIDTH-1:0]  executionTag_in;
   logic [DATA_WIDTH-1:0] data_0;
   logic [DATA_WIDTH-1:0] data_1;
   logic [DATA_WIDTH-1:0] result;
   logic                  done;
   logic [TAG_WIDTH-1:0]  executionTag_out;
   logic                  queued;

   modport master (
      output ce, opcode, executionTag_in, data_0, data_1, queued,
      input  idle, result, done, executionTag_out
   );

   modport slave (
      input  ce, opcode, executionTag_in, data_0, data_1, queued,
      output idle, result, done, executionTag_out
   );
endinterface

// File: rtl/fu_logic_pipe.sv
// Pipelined bitwise logic unit: eight operations, one issue per cycle,
// LATENCY-cycle pipeline into a DEPTH-entry in-order completion buffer.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : issue/completion bus (slave side), see fu_logic_pipe_if
module fu_logic_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LATENCY    = 1,
   parameter int unsigned TAG_WIDTH  = 7,
   parameter int unsigned DEPTH      = 2
) (
   input logic             clk,
   input logic             rst,
   fu_logic_pipe_if.slave  bus
);

   localparam int unsigned OCC_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [TAG_WIDTH-1:0]  tag;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   logic             accept_c;
   logic             pop_c;
   entry_t           issue_c;
   logic             wr_en_c;
   entry_t           wr_entry_c;

   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_n;
   logic [OCC_W-1:0] cnt_q;
   logic [OCC_W-1:0] cnt_n;
   logic [PTR_W-1:0] rd_q;
   logic [PTR_W-1:0] rd_n;
   logic [PTR_W-1:0] wr_q;
   logic [PTR_W-1:0] wr_n;
   logic             idle_q;
   logic             done_q;
   entry_t           head_q;
   entry_t           head_n;
   entry_t           mem [DEPTH];

   // Handshakes; idle_q/done_q are registered so neither depends on ce/queued.
   assign accept_c = bus.ce & idle_q;
   assign pop_c    = bus.queued & done_q;

   // Operation evaluated at the input; only the registered copy matters.
   always_comb begin : op_compute
      issue_c.tag = bus.executionTag_in;
      case (bus.opcode)
         3'd0:    issue_c.data = bus.data_0 & bus.data_1;
         3'd1:    issue_c.data = bus.data_0 | bus.data_1;
         3'd2:    issue_c.data = bus.data_0 ^ bus.data_1;
         3'd3:    issue_c.data = ~(bus.data_0 | bus.data_1);
         3'd4:    issue_c.data = bus.data_0 & ~bus.data_1;
         3'd5:    issue_c.data = bus.data_0 | ~bus.data_1;
         3'd6:    issue_c.data = ~(bus.data_0 ^ bus.data_1);
         default: issue_c.data = bus.data_0;
      endcase
   end

   // LATENCY-1 non-stalling stages; only the valid bits need a reset.
   generate
      if (LATENCY == 1) begin : g_direct
         assign wr_en_c    = accept_c;
         assign wr_entry_c = issue_c;
      end else begin : g_pipe
         localparam int unsigned STAGES = LATENCY - 1;

         logic [STAGES-1:0] vld_q;
         entry_t            pay_q [STAGES];

         always_ff @(posedge clk) begin : valid_shift
            if (rst) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= accept_c;
               for (int i = 1; i < STAGES; i++) begin
                  vld_q[i] <= vld_q[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin : payload_shift
            pay_q[0] <= issue_c;
            for (int i = 1; i < STAGES; i++) begin
               pay_q[i] <= pay_q[i-1];
            end
         end

         assign wr_en_c    = vld_q[STAGES-1];
         assign wr_entry_c = pay_q[STAGES-1];
      end
   endgenerate

   // Circular increment for any DEPTH, not just powers of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Next credit count, buffer fill, pointers and head entry.
   always_comb begin : next_state
      occ_n  = occ_q + OCC_W'(accept_c) - OCC_W'(pop_c);
      cnt_n  = cnt_q + OCC_W'(wr_en_c) - OCC_W'(pop_c);
      rd_n   = pop_c   ? ptr_inc(rd_q) : rd_q;
      wr_n   = wr_en_c ? ptr_inc(wr_q) : wr_q;
      head_n = '0;
      if (cnt_n != '0) begin
         // A write landing on the new read slot becomes the head immediately.
         if (wr_en_c && (wr_q == rd_n)) begin
            head_n = wr_entry_c;
         end else begin
            head_n = mem[rd_n];
         end
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge clk) begin : state_regs
      if (rst) begin
         occ_q  <= '0;
         cnt_q  <= '0;
         rd_q   <= '0;
         wr_q   <= '0;
         idle_q <= 1'b1;
         done_q <= 1'b0;
         head_q <= '0;
      end else begin
         occ_q  <= occ_n;
         cnt_q  <= cnt_n;
         rd_q   <= rd_n;
         wr_q   <= wr_n;
         idle_q <= (occ_n < OCC_W'(DEPTH));
         done_q <= (cnt_n != '0);
         head_q <= head_n;
      end
   end

   // Buffer storage; contents are don't-care until written.
   always_ff @(posedge clk) begin : buffer_write
      if (wr_en_c) begin
         mem[wr_q] <= wr_entry_c;
      end
   end

   assign bus.idle             = idle_q;
   assign bus.done             = done_q;
   assign bus.result           = head_q.data;
   assign bus.executionTag_out = head_q.tag;

endmodule

// File: tb/tb_fu_logic_pipe.sv
// Self-checking bench for fu_logic_pipe across three configurations:
//   dut_a LATENCY=1 DEPTH=2, dut_b LATENCY=3 DEPTH=2, dut_c LATENCY=2 DEPTH=3.
module tb_fu_logic_pipe;

   localparam int unsigned DW = 32;
   localparam int unsigned TW = 7;

   logic   clk = 1'b0;
   logic   rst_a;
   logic   rst_b;
   logic   rst_c;
   int     n_tests = 0;
   int     n_fail  = 0;
   longint cyc     = 0;

   always #5 clk = ~clk;

   fu_logic_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) ifa ();
   fu_logic_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) ifb ();
   fu_logic_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) ifc ();

   fu_logic_pipe #(.DATA_WIDTH(DW), .LATENCY(1), .TAG_WIDTH(TW), .DEPTH(2))
      dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
   fu_logic_pipe #(.DATA_WIDTH(DW), .LATENCY(3), .TAG_WIDTH(TW), .DEPTH(2))
      dut_b (.clk(clk), .rst(rst_b), .bus(ifb));
   fu_logic_pipe #(.DATA_WIDTH(DW), .LATENCY(2), .TAG_WIDTH(TW), .DEPTH(3))
      dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference: each opcode as a 2-input truth table indexed by {d0 bit, d1 bit}.
   function automatic logic [DW-1:0] ref_op(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      logic [3:0]    tt;
      logic [DW-1:0] r;
      case (op)
         3'd0:    tt = 4'b1000;
         3'd1:    tt = 4'b1110;
         3'd2:    tt = 4'b0110;
         3'd3:    tt = 4'b0001;
         3'd4:    tt = 4'b0100;
         3'd5:    tt = 4'b1101;
         3'd6:    tt = 4'b1001;
         default: tt = 4'b1100;
      endcase
      for (int i = 0; i < int'(DW); i++) r[i] = tt[{a[i], b[i]}];
      return r;
   endfunction

   // ---------------- model for dut_c (LATENCY=2, DEPTH=3) ----------------
   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
      longint        ready;
   } ment_t;

   ment_t mq[$];
   int    max_occ_c = 0;
   int    dut_pops_c = 0;

   task automatic step_c(input logic ce, input logic q, input logic [2:0] op,
                         input logic [TW-1:0] tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic exp_idle;
      logic exp_done;
      logic acc;
      logic pop;
      exp_idle = (mq.size() < 3);
      exp_done = (mq.size() > 0) && (mq[0].ready <= cyc);
      check("c_idle", 64'(ifc.idle), 64'(exp_idle));
      check("c_done", 64'(ifc.done), 64'(exp_done));
      check("c_tag", 64'(ifc.executionTag_out), exp_done ? 64'(mq[0].tag) : 64'd0);
      check("c_result", 64'(ifc.result), exp_done ? 64'(mq[0].data) : 64'd0);
      check("c_occ", 64'(dut_c.occ_q), 64'(mq.size()));
      if (ifc.done && q) dut_pops_c++;
      ifc.ce              = ce;
      ifc.queued          = q;
      ifc.opcode          = op;
      ifc.executionTag_in = tag;
      ifc.data_0          = a;
      ifc.data_1          = b;
      acc = ce && exp_idle;
      pop = exp_done && q;
      tick();
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{tag, ref_op(op, a, b), cyc + 1});
      if (int'(dut_c.occ_q) > max_occ_c) max_occ_c = int'(dut_c.occ_q);
   endtask

   // ---------------- opcode sweep table ----------------
   typedef struct {
      logic [2:0]    op;
      logic [TW-1:0] tag;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t vt[8];

   initial begin
      logic spurious;

      vt[0] = '{3'd0, 7'd1, 32'hF000_F000};
      vt[1] = '{3'd1, 7'd2, 32'hFFF0_FFF0};
      vt[2] = '{3'd2, 7'd3, 32'h0FF0_0FF0};
      vt[3] = '{3'd3, 7'd4, 32'h000F_000F};
      vt[4] = '{3'd4, 7'd5, 32'h00F0_00F0};
      vt[5] = '{3'd5, 7'd6, 32'hF0FF_F0FF};
      vt[6] = '{3'd6, 7'd7, 32'hF00F_F00F};
      vt[7] = '{3'd7, 7'd8, 32'hF0F0_F0F0};

      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      {ifa.ce, ifa.queued, ifa.opcode, ifa.executionTag_in, ifa.data_0, ifa.data_1} = '0;
      {ifb.ce, ifb.queued, ifb.opcode, ifb.executionTag_in, ifb.data_0, ifb.data_1} = '0;
      {ifc.ce, ifc.queued, ifc.opcode, ifc.executionTag_in, ifc.data_0, ifc.data_1} = '0;

      // Reset defaults
      tick();
      tick();
      rst_a = 1'b0;
      check("rst_idle", 64'(ifa.idle), 64'd1);
      check("rst_done", 64'(ifa.done), 64'd0);
      check("rst_result", 64'(ifa.result), 64'd0);
      check("rst_tag", 64'(ifa.executionTag_out), 64'd0);

      // Opcode sweep, back-to-back with queued held high
      ifa.queued = 1'b1;
      ifa.data_0 = 32'hF0F0_F0F0;
      ifa.data_1 = 32'hFF00_FF00;
      for (int i = 0; i < 8; i++) begin
         check("sweep_idle", 64'(ifa.idle), 64'd1);
         ifa.ce              = 1'b1;
         ifa.opcode          = vt[i].op;
         ifa.executionTag_in = vt[i].tag;
         tick();
         check("sweep_done", 64'(ifa.done), 64'd1);
         check("sweep_result", 64'(ifa.result), 64'(vt[i].exp));
         check("sweep_tag", 64'(ifa.executionTag_out), 64'(vt[i].tag));
      end
      ifa.ce = 1'b0;
      tick();
      check("sweep_drained", 64'(ifa.done), 64'd0);

      // Backpressure and credit (LATENCY=3, DEPTH=2)
      rst_b = 1'b0;
      tick();
      ifb.queued          = 1'b0;
      ifb.ce              = 1'b1;
      ifb.opcode          = 3'd1;
      ifb.data_0          = 32'h1234_5678;
      ifb.data_1          = 32'h0F0F_0000;
      ifb.executionTag_in = 7'd5;
      tick();
      ifb.executionTag_in = 7'd6;
      tick();
      check("bp_idle_full", 64'(ifb.idle), 64'd0);
      ifb.executionTag_in = 7'd7;
      tick();
      ifb.ce = 1'b0;
      check("bp_done5", 64'(ifb.done), 64'd1);
      check("bp_tag5", 64'(ifb.executionTag_out), 64'd5);
      check("bp_result5", 64'(ifb.result), 64'h1F3F_5678);
      tick();
      tick();
      check("bp_hold5", 64'(ifb.executionTag_out), 64'd5);
      check("bp_idle_hold", 64'(ifb.idle), 64'd0);
      check("bp_occ_full", 64'(dut_b.occ_q), 64'd2);
      ifb.queued = 1'b1;
      tick();
      ifb.queued = 1'b0;
      check("bp_tag6", 64'(ifb.executionTag_out), 64'd6);
      check("bp_idle_back", 64'(ifb.idle), 64'd1);
      ifb.queued = 1'b1;
      tick();
      ifb.queued = 1'b0;
      check("bp_empty", 64'(ifb.done), 64'd0);
      tick();
      tick();
      tick();
      check("bp_tag7_dropped", 64'(ifb.done), 64'd0);

      // Simultaneous accept and pop at occ=1
      ifb.ce              = 1'b1;
      ifb.executionTag_in = 7'd9;
      tick();
      ifb.ce = 1'b0;
      tick();
      tick();
      check("sim_done9", 64'(ifb.done), 64'd1);
      check("sim_tag9", 64'(ifb.executionTag_out), 64'd9);
      ifb.ce              = 1'b1;
      ifb.queued          = 1'b1;
      ifb.executionTag_in = 7'd10;
      tick();
      ifb.ce     = 1'b0;
      ifb.queued = 1'b0;
      check("sim_occ", 64'(dut_b.occ_q), 64'd1);
      check("sim_idle", 64'(ifb.idle), 64'd1);
      check("sim_gap", 64'(ifb.done), 64'd0);
      tick();
      tick();
      check("sim_done10", 64'(ifb.done), 64'd1);
      check("sim_tag10", 64'(ifb.executionTag_out), 64'd10);
      ifb.queued = 1'b1;
      tick();
      ifb.queued = 1'b0;
      check("sim_drained", 64'(ifb.done), 64'd0);

      // Reset mid-operation, asserted together with ce
      ifb.ce              = 1'b1;
      ifb.executionTag_in = 7'd11;
      tick();
      ifb.executionTag_in = 7'd12;
      tick();
      rst_b               = 1'b1;
      ifb.executionTag_in = 7'd13;
      tick();
      check("mid_rst_done", 64'(ifb.done), 64'd0);
      check("mid_rst_idle", 64'(ifb.idle), 64'd1);
      check("mid_rst_occ", 64'(dut_b.occ_q), 64'd0);
      check("mid_rst_tag", 64'(ifb.executionTag_out), 64'd0);
      rst_b    = 1'b0;
      ifb.ce   = 1'b0;
      spurious = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ifb.done !== 1'b0) spurious = 1'b1;
      end
      check("mid_rst_no_spurious", 64'(spurious), 64'd0);

      // Full-rate streaming (LATENCY=2, DEPTH=3)
      rst_c = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) begin
         step_c(1'b1, 1'b1, 3'($urandom_range(0, 7)), TW'(i + 1), $urandom, $urandom);
      end
      for (int i = 0; i < 4; i++) step_c(1'b0, 1'b1, 3'd0, '0, '0, '0);
      check("stream_completions", 64'(dut_pops_c), 64'd20);
      check("stream_occ_bound", 64'(max_occ_c <= 3), 64'd1);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step_c(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 5),
                3'($urandom_range(0, 7)), TW'($urandom), $urandom, $urandom);
      end
      for (int i = 0; i < 8; i++) step_c(1'b0, 1'b1, 3'd0, '0, '0, '0);
      check("rand_drained", 64'(ifc.done), 64'd0);
      check("rand_occ_bound", 64'(max_occ_c <= 3), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
